// File: rtl/csync_serration_gen.sv
// csync_serration_gen
//   Composite-sync generator for the external csync input of the VGA
//   scandoubler (composite path). It turns the core's separate active-low
//   hsync/vsync into broadcast-style csync_n with pre-equalising pulses,
//   serrated broad pulses and post-equalising pulses around vertical sync.
//   The line length is measured continuously, so PAL and NTSC both work
//   without reconfiguration. Whenever the measured line length is outside
//   [LINE_MIN, LINE_MAX], the output falls back to hsync_n & vsync_n.
//
// Ports
//   clk          system clock (28 MHz)
//   rst          synchronous reset, active high
//   clk14en      14 MHz clock enable; all sampling and counting happen on it
//   hsync_n      horizontal sync from the core, active low
//   vsync_n      vertical sync from the core, active low
//   csync_n      composite sync, active low, registered
//   locked       measured line length currently valid
//   vseq_active  high while the equalising/broad sequence is being emitted
module csync_serration_gen #(
  parameter int EQ_W      = 33,
  parameter int BROAD_GAP = 66,
  parameter int N_EQ      = 5,
  parameter int N_BROAD   = 5,
  parameter int LINE_MIN  = 800,
  parameter int LINE_MAX  = 960,
  parameter int CNTW      = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clk14en,
  input  logic hsync_n,
  input  logic vsync_n,
  output logic csync_n,
  output logic locked,
  output logic vseq_active
);

  localparam int HL_MAX = (N_EQ > N_BROAD) ? N_EQ : N_BROAD;
  localparam int HLW    = $clog2(HL_MAX + 1);

  // Constants pre-sized to the CNTW+1 compare width so that all arithmetic
  // around half-line lengths stays unsigned and non-negative.
  localparam logic [CNTW:0]   LMIN    = (CNTW+1)'(LINE_MIN);
  localparam logic [CNTW:0]   LMAX    = (CNTW+1)'(LINE_MAX);
  localparam logic [CNTW:0]   EQW     = (CNTW+1)'(EQ_W);
  localparam logic [CNTW:0]   BGAP    = (CNTW+1)'(BROAD_GAP);
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [HLW-1:0]  HL_EQ   = HLW'(N_EQ);
  localparam logic [HLW-1:0]  HL_BRD  = HLW'(N_BROAD);

  typedef enum logic [2:0] {
    S_NORMAL,
    S_ARM,
    S_PRE_EQ,
    S_BROAD,
    S_POST_EQ
  } state_t;

  state_t          state, state_nx;
  logic            hs_s, vs_s;          // previous tick's samples
  logic [CNTW-1:0] line_cnt;
  logic [CNTW:0]   line_len;            // one extra bit: line_cnt+1 can reach 2^CNTW
  logic [CNTW-1:0] ph;
  logic [HLW-1:0]  hl_cnt, hl_nx;

  logic            hfall, vfall;
  logic [CNTW:0]   line_cnt_p1;
  logic [CNTW-1:0] half;
  logic [CNTW:0]   half_ext, half_m1, brd_w;
  logic            wrap;
  logic [CNTW-1:0] ph_nx;
  logic            boundary;
  logic            lock_nx;
  logic            broad_low;
  logic            cs_nx, va_nx;
  logic [HLW-1:0]  hl_p1;

  // Edges compare the previous tick's sample with the value sampled now.
  assign hfall = hs_s & ~hsync_n;
  assign vfall = vs_s & ~vsync_n;

  assign line_cnt_p1 = {1'b0, line_cnt} + 1'b1;
  assign half        = CNTW'(line_len >> 1);
  assign half_ext    = {1'b0, half};
  // With half==0 (nothing measured yet) half_m1 is all ones and never
  // matches ph, so ph simply rolls over at 2^CNTW.
  assign half_m1     = half_ext - 1'b1;
  assign wrap        = ({1'b0, ph} == half_m1);

  // hsync fall and wrap on the same tick collapse into one boundary.
  assign ph_nx    = (hfall || wrap) ? '0 : ph + 1'b1;
  assign boundary = (ph_nx == '0);

  always_comb begin
    lock_nx = locked;
    if (hfall)
      lock_nx = (line_cnt_p1 >= LMIN) && (line_cnt_p1 <= LMAX);
    else if ({1'b0, line_cnt} > LMAX)
      lock_nx = 1'b0;
  end

  // Broad low width is half-BROAD_GAP; a too-short half-line keeps the
  // pulse low throughout instead of underflowing.
  assign brd_w     = half_ext - BGAP;
  assign broad_low = (half_ext <= BGAP) || ({1'b0, ph} < brd_w);

  assign hl_p1 = hl_cnt + 1'b1;

  always_comb begin
    state_nx = state;
    hl_nx    = hl_cnt;
    case (state)
      S_NORMAL: begin
        // The hsync-forced boundary on this same tick is not counted:
        // ARM waits for the next one.
        if (vfall && locked) begin
          state_nx = S_ARM;
          hl_nx    = '0;
        end
      end
      S_ARM: begin
        if (boundary) begin
          state_nx = S_PRE_EQ;
          hl_nx    = '0;
        end
      end
      S_PRE_EQ: begin
        if (boundary) begin
          if (hl_p1 == HL_EQ) begin
            state_nx = S_BROAD;
            hl_nx    = '0;
          end else begin
            hl_nx = hl_p1;
          end
        end
      end
      S_BROAD: begin
        if (boundary) begin
          if (hl_p1 == HL_BRD) begin
            state_nx = S_POST_EQ;
            hl_nx    = '0;
          end else begin
            hl_nx = hl_p1;
          end
        end
      end
      S_POST_EQ: begin
        if (boundary) begin
          if (hl_p1 == HL_EQ) begin
            state_nx = S_NORMAL;
            hl_nx    = '0;
          end else begin
            hl_nx = hl_p1;
          end
        end
      end
      default: begin
        state_nx = S_NORMAL;
        hl_nx    = '0;
      end
    endcase
    // Losing lock aborts any sequence on the tick it happens so csync_n
    // can never be held low by a stale sequence.
    if (state != S_NORMAL && !lock_nx) begin
      state_nx = S_NORMAL;
      hl_nx    = '0;
    end
  end

  always_comb begin
    cs_nx = 1'b1;
    va_nx = 1'b0;
    case (state)
      S_NORMAL:  cs_nx = locked ? hsync_n : (hsync_n & vsync_n);
      S_ARM:     cs_nx = hsync_n;
      S_PRE_EQ,
      S_POST_EQ: begin
        cs_nx = ({1'b0, ph} >= EQW);
        va_nx = 1'b1;
      end
      S_BROAD: begin
        cs_nx = ~broad_low;
        va_nx = 1'b1;
      end
      default:   cs_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_s        <= 1'b1;
      vs_s        <= 1'b1;
      line_cnt    <= '0;
      line_len    <= '0;
      ph          <= '0;
      hl_cnt      <= '0;
      locked      <= 1'b0;
      state       <= S_NORMAL;
      csync_n     <= 1'b1;
      vseq_active <= 1'b0;
    end else if (clk14en) begin
      hs_s <= hsync_n;
      vs_s <= vsync_n;
      if (hfall) begin
        line_len <= line_cnt_p1;
        line_cnt <= '0;
      end else if (line_cnt != CNT_MAX) begin
        line_cnt <= line_cnt_p1[CNTW-1:0];
      end
      ph          <= ph_nx;
      locked      <= lock_nx;
      state       <= state_nx;
      hl_cnt      <= hl_nx;
      csync_n     <= cs_nx;
      vseq_active <= va_nx;
    end
  end

endmodule
